// File: rtl/memoria_param_if.sv
// Request/response bundle between the datapath and memoria_param.
// The master drives requests; the slave returns read data, the valid strobe and busy.
interface memoria_param_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2
);
    logic              en;
    logic              wr;
    logic [LANES-1:0]  wmask;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout;
    logic              dvalid;
    logic              busy;

    modport master (
        output en, wr, wmask, address, datain,
        input  dataout, dvalid, busy
    );

    modport slave (
        input  en, wr, wmask, address, datain,
        output dataout, dvalid, busy
    );
endinterface

// File: rtl/memoria_param.sv
// Parametrised single-port RAM with lane write mask and post-reset clear; response after RD_LAT cycles.
// No backpressure: one request per cycle while ready, requests dropped while busy (clearing).
module memoria_param #(
    parameter int DATA_W       = 14,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 32,
    parameter int LANE_W       = 7,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1,
    parameter     INIT_FILE    = "memoria.txt"
) (
    input  logic            clk,
    input  logic            rst,
    memoria_param_if.slave  bus
);
    localparam int                LANES   = DATA_W / LANE_W;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              busy_q;
    logic              dvalid_q;
    logic [DATA_W-1:0] dataout_q;
    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;
    logic [DATA_W-1:0] resp;

    // Out-of-range addresses read as zero and never touch the array.
    always_comb begin
        accept   = bus.en && !busy_q;
        in_range = {1'b0, bus.address} < DEPTH_W;
        old_word = in_range ? mem[bus.address] : '0;
        new_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (bus.wmask[i]) begin
                new_word[i*LANE_W +: LANE_W] = bus.datain[i*LANE_W +: LANE_W];
            end
        end
        resp = old_word;
        if (bus.wr && (RDW_MODE != 0) && in_range) begin
            resp = new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (accept && bus.wr && in_range) begin
                mem[bus.address] <= new_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataout_q <= '0;
            dvalid_q  <= 1'b0;
            s1_dat    <= '0;
            s1_vld    <= 1'b0;
            cnt       <= '0;
            if (CLEAR_ON_RST != 0) begin
                state  <= CLEAR;
                busy_q <= 1'b1;
            end else begin
                state  <= READY;
                busy_q <= 1'b0;
            end
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_dat <= resp;
            end
            // Second latency stage drains s1; single-stage variant bypasses it.
            if (RD_LAT == 2) begin
                dvalid_q <= s1_vld;
                if (s1_vld) begin
                    dataout_q <= s1_dat;
                end
            end else begin
                dvalid_q <= accept;
                if (accept) begin
                    dataout_q <= resp;
                end
            end
            case (state)
                CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= READY;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dataout = dataout_q;
    assign bus.dvalid  = dvalid_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_memoria_param.sv
// Directed bench: instance A (RD_LAT=1, read-first, DEPTH=32), instance B (RD_LAT=2, write-first, DEPTH=24).
module tb_memoria_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memoria_param_if #(.DATA_W(14), .ADDR_W(5), .LANES(2)) bus_a ();
    memoria_param_if #(.DATA_W(14), .ADDR_W(5), .LANES(2)) bus_b ();

    memoria_param #(.DATA_W(14), .ADDR_W(5), .DEPTH(32), .LANE_W(7), .RD_LAT(1),
                    .RDW_MODE(0), .CLEAR_ON_RST(1), .INIT_FILE(""))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    memoria_param #(.DATA_W(14), .ADDR_W(5), .DEPTH(24), .LANE_W(7), .RD_LAT(2),
                    .RDW_MODE(1), .CLEAR_ON_RST(1), .INIT_FILE(""))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [1:0]  wmask;
        logic [4:0]  addr;
        logic [13:0] din;
        logic        exp_vld;
        logic [13:0] exp_dat;
    } vec_t;

    vec_t va [0:18];
    vec_t vb [0:12];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic en, input logic wr, input logic [1:0] m,
                                input logic [4:0] a, input logic [13:0] d,
                                input logic ev, input logic [13:0] ed);
        vec_t v;
        v.en = en; v.wr = wr; v.wmask = m; v.addr = a; v.din = d;
        v.exp_vld = ev; v.exp_dat = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input vec_t v);
        bus_a.en = v.en; bus_a.wr = v.wr; bus_a.wmask = v.wmask;
        bus_a.address = v.addr; bus_a.datain = v.din;
    endtask

    task automatic drive_b(input vec_t v);
        bus_b.en = v.en; bus_b.wr = v.wr; bus_b.wmask = v.wmask;
        bus_b.address = v.addr; bus_b.datain = v.din;
    endtask

    // Counts edges after rst release until each busy drops; a bound of 100 edges.
    task automatic count_clear(output int na, output int nb, output bit saw);
        na = 0; nb = 0; saw = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus_a.dvalid || bus_b.dvalid) saw = 1'b1;
            if (na == 0 && !bus_a.busy) na = k;
            if (nb == 0 && !bus_b.busy) nb = k;
            if (na != 0 && nb != 0) break;
        end
    endtask

    int na, nb;
    bit saw;

    initial begin
        va[0]  = mk(1, 1, 3,  5, 14'h2A5F, 1, 14'h0000);
        va[1]  = mk(1, 0, 0,  5, 14'h0000, 1, 14'h2A5F);
        va[2]  = mk(0, 0, 0,  5, 14'h0000, 0, 14'h2A5F);
        va[3]  = mk(1, 1, 3,  3, 14'h3FFF, 1, 14'h0000);
        va[4]  = mk(1, 1, 1,  3, 14'h0000, 1, 14'h3FFF);
        va[5]  = mk(1, 0, 0,  3, 14'h0000, 1, 14'h3F80);
        va[6]  = mk(1, 1, 3,  7, 14'h0011, 1, 14'h0000);
        va[7]  = mk(1, 1, 3,  7, 14'h0022, 1, 14'h0011);
        va[8]  = mk(1, 0, 0,  7, 14'h0000, 1, 14'h0022);
        va[9]  = mk(1, 1, 0,  9, 14'h1555, 1, 14'h0000);
        va[10] = mk(1, 0, 0,  9, 14'h0000, 1, 14'h0000);
        va[11] = mk(1, 1, 2, 31, 14'h1ABC, 1, 14'h0000);
        va[12] = mk(1, 0, 0, 31, 14'h0000, 1, 14'h1A80);
        va[13] = mk(0, 1, 3,  9, 14'h0FFF, 0, 14'h1A80);
        va[14] = mk(1, 0, 0,  9, 14'h0000, 1, 14'h0000);
        va[15] = mk(1, 1, 3,  0, 14'h0123, 1, 14'h0000);
        va[16] = mk(1, 0, 0,  0, 14'h0000, 1, 14'h0123);
        va[17] = mk(1, 1, 2,  0, 14'h007F, 1, 14'h0123);
        va[18] = mk(1, 0, 0,  0, 14'h0000, 1, 14'h0023);

        vb[0]  = mk(1, 1, 3,  0, 14'h0101, 1, 14'h0101);
        vb[1]  = mk(1, 1, 3,  1, 14'h0202, 1, 14'h0202);
        vb[2]  = mk(1, 1, 3,  2, 14'h0303, 1, 14'h0303);
        vb[3]  = mk(1, 0, 0,  0, 14'h0000, 1, 14'h0101);
        vb[4]  = mk(1, 0, 0,  1, 14'h0000, 1, 14'h0202);
        vb[5]  = mk(1, 0, 0,  2, 14'h0000, 1, 14'h0303);
        vb[6]  = mk(1, 1, 3,  7, 14'h0011, 1, 14'h0011);
        vb[7]  = mk(1, 1, 3,  7, 14'h0022, 1, 14'h0022);
        vb[8]  = mk(1, 1, 1, 23, 14'h3FFF, 1, 14'h007F);
        vb[9]  = mk(1, 1, 3, 24, 14'h1234, 1, 14'h0000);
        vb[10] = mk(1, 0, 0, 24, 14'h0000, 1, 14'h0000);
        vb[11] = mk(1, 0, 0, 23, 14'h0000, 1, 14'h007F);
        vb[12] = mk(0, 0, 0,  0, 14'h0000, 0, 14'h007F);

        // Reset and clear: a write to A during clear must be dropped.
        rst = 1'b1;
        drive_a(mk(0, 0, 0, 0, 0, 0, 0));
        drive_b(mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        chk("rst A out", 32'({bus_a.busy, bus_a.dvalid, bus_a.dataout}), 32'({1'b1, 1'b0, 14'h0}));
        chk("rst B out", 32'({bus_b.busy, bus_b.dvalid, bus_b.dataout}), 32'({1'b1, 1'b0, 14'h0}));
        drive_a(mk(1, 1, 3, 4, 14'h1111, 0, 0));
        rst = 1'b0;
        count_clear(na, nb, saw);
        drive_a(mk(0, 0, 0, 0, 0, 0, 0));
        chk("clear cycles A", 32'(na), 32'd32);
        chk("clear cycles B", 32'(nb), 32'd24);
        chk("dvalid during clear", 32'(saw), 32'd0);

        for (int i = 0; i < 32; i++) begin
            drive_a(mk(1, 0, 0, 5'(i), 0, 0, 0));
            tick();
            chk($sformatf("A cleared @%0d", i), 32'({bus_a.dvalid, bus_a.dataout}), 32'({1'b1, 14'h0}));
        end

        for (int i = 0; i < 19; i++) begin
            drive_a(va[i]);
            tick();
            chk($sformatf("A vec %0d", i), 32'({bus_a.dvalid, bus_a.dataout}),
                32'({va[i].exp_vld, va[i].exp_dat}));
        end
        drive_a(mk(0, 0, 0, 0, 0, 0, 0));

        // B stream: response for request c-1 is visible after edge c.
        for (int c = 0; c <= 13; c++) begin
            if (c < 13) drive_b(vb[c]);
            else        drive_b(mk(0, 0, 0, 0, 0, 0, 0));
            tick();
            if (c == 0)
                chk("B lat2 first edge", 32'({bus_b.dvalid, bus_b.dataout}), 32'({1'b0, 14'h0}));
            else
                chk($sformatf("B vec %0d", c - 1), 32'({bus_b.dvalid, bus_b.dataout}),
                    32'({vb[c-1].exp_vld, vb[c-1].exp_dat}));
        end

        // Reset with a B read in flight, then reset again 10 edges into clear.
        drive_b(mk(1, 0, 0, 0, 0, 0, 0));
        tick();
        drive_b(mk(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        tick();
        chk("inflight B dropped", 32'({bus_b.busy, bus_b.dvalid, bus_b.dataout}), 32'({1'b1, 1'b0, 14'h0}));
        chk("rst2 A busy", 32'(bus_a.busy), 32'd1);
        tick();
        chk("inflight B still none", 32'(bus_b.dvalid), 32'd0);
        rst = 1'b0;
        drive_a(mk(1, 0, 0, 5, 0, 0, 0));
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus_a.dvalid || bus_b.dvalid || !bus_a.busy) saw = 1'b1;
        end
        chk("partial clear quiet", 32'(saw), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid-clear rst busy", 32'({bus_a.busy, bus_b.busy, bus_a.dvalid}), 32'({1'b1, 1'b1, 1'b0}));
        rst = 1'b0;
        count_clear(na, nb, saw);
        drive_a(mk(0, 0, 0, 0, 0, 0, 0));
        chk("restart cycles A", 32'(na), 32'd32);
        chk("restart cycles B", 32'(nb), 32'd24);
        chk("dvalid during restart", 32'(saw), 32'd0);

        // Contents wiped by the second clear.
        drive_a(mk(1, 0, 0, 5, 0, 0, 0));
        drive_b(mk(1, 0, 0, 0, 0, 0, 0));
        tick();
        drive_a(mk(0, 0, 0, 0, 0, 0, 0));
        drive_b(mk(0, 0, 0, 0, 0, 0, 0));
        chk("A @5 after reclear", 32'({bus_a.dvalid, bus_a.dataout}), 32'({1'b1, 14'h0}));
        chk("B not yet valid", 32'(bus_b.dvalid), 32'd0);
        tick();
        chk("B @0 after reclear", 32'({bus_b.dvalid, bus_b.dataout}), 32'({1'b1, 14'h0}));
        chk("A strobe one cycle", 32'(bus_a.dvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
